// File: rtl/rom_loader_if.sv
// Upstream byte-stream handshake used by rom_loader; the loader is the slave.
interface rom_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (output byte_valid, output byte_data, input byte_ready);
  modport slave  (input byte_valid, input byte_data, output byte_ready);
endinterface

// File: rtl/rom_loader.sv
// Streams a length-prefixed big-endian program into instruction ROM and holds the CPU in reset until it lands.
// Optional trailing XOR checksum enabled by defining ROM_LOADER_CHECKSUM_EN.
module rom_loader #(
  parameter int ADDRESS_WIDTH = 10
) (
  input  logic                     clock,
  input  logic                     reset,
  rom_loader_if.slave              bus,
  input  logic                     reload,
  output logic                     rom_write_enable,
  output logic [ADDRESS_WIDTH-1:0] rom_write_address,
  output logic [31:0]              rom_write_data,
  output logic                     cpu_reset,
  output logic                     load_done,
  output logic                     load_error
);

  typedef enum logic [2:0] {
    COUNT_HI,
    COUNT_LO,
    DATA,
`ifdef ROM_LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE,
    ERROR
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  state_t                   w_endState;
  logic                     r_byteReady;
  logic [7:0]               r_countHi;
  logic [15:0]              r_count;
  logic [ADDRESS_WIDTH-1:0] r_index;
  logic [1:0]               r_byteCnt;
  logic [23:0]              r_shift;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0]               r_checksum;
`endif

  logic        w_xfer;
  logic [15:0] w_count;
  logic        w_countTooBig;
  logic        w_lastWord;

  assign bus.byte_ready = r_byteReady;
  assign w_xfer         = bus.byte_valid & r_byteReady;
  assign w_count        = {r_countHi, bus.byte_data};
  // Exactly 2^ADDRESS_WIDTH words fills the ROM; one more would wrap the address.
  assign w_countTooBig  = 32'(w_count) > (32'd1 << ADDRESS_WIDTH);
  assign w_lastWord     = (32'(r_index) + 32'd1) == 32'(r_count);

`ifdef ROM_LOADER_CHECKSUM_EN
  assign w_endState = CHECK;
`else
  assign w_endState = DONE;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      COUNT_HI: if (w_xfer) w_next = COUNT_LO;
      COUNT_LO: begin
        if (w_xfer) begin
          if (w_countTooBig)        w_next = ERROR;
          else if (w_count == 16'd0) w_next = w_endState;
          else                       w_next = DATA;
        end
      end
      DATA: if (w_xfer && (r_byteCnt == 2'd3) && w_lastWord) w_next = w_endState;
`ifdef ROM_LOADER_CHECKSUM_EN
      CHECK: if (w_xfer) w_next = (bus.byte_data == r_checksum) ? DONE : ERROR;
`endif
      DONE, ERROR: if (reload) w_next = COUNT_HI;
      default: w_next = COUNT_HI;
    endcase
  end

  // Status outputs are registered from the next state so they always agree with r_state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state           <= COUNT_HI;
      r_byteReady       <= 1'b1;
      cpu_reset         <= 1'b1;
      load_done         <= 1'b0;
      load_error        <= 1'b0;
      rom_write_enable  <= 1'b0;
      rom_write_address <= '0;
      rom_write_data    <= '0;
      r_countHi         <= '0;
      r_count           <= '0;
      r_index           <= '0;
      r_byteCnt         <= '0;
      r_shift           <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
      r_checksum        <= '0;
`endif
    end else begin
      r_state          <= w_next;
      r_byteReady      <= (w_next != DONE) && (w_next != ERROR);
      cpu_reset        <= (w_next != DONE);
      load_done        <= (w_next == DONE);
      load_error       <= (w_next == ERROR);
      rom_write_enable <= 1'b0;
      case (r_state)
        COUNT_HI: begin
          if (w_xfer) begin
            r_countHi <= bus.byte_data;
`ifdef ROM_LOADER_CHECKSUM_EN
            r_checksum <= r_checksum ^ bus.byte_data;
`endif
          end
        end
        COUNT_LO: begin
          if (w_xfer) begin
            r_count <= w_count;
`ifdef ROM_LOADER_CHECKSUM_EN
            r_checksum <= r_checksum ^ bus.byte_data;
`endif
          end
        end
        DATA: begin
          if (w_xfer) begin
            r_byteCnt <= r_byteCnt + 2'd1;
`ifdef ROM_LOADER_CHECKSUM_EN
            r_checksum <= r_checksum ^ bus.byte_data;
`endif
            if (r_byteCnt == 2'd3) begin
              rom_write_enable  <= 1'b1;
              rom_write_data    <= {r_shift, bus.byte_data};
              rom_write_address <= r_index;
              r_index           <= r_index + 1'b1;
            end else begin
              r_shift <= {r_shift[15:0], bus.byte_data};
            end
          end
        end
        DONE, ERROR: begin
          if (reload) begin
            r_countHi <= '0;
            r_count   <= '0;
            r_index   <= '0;
            r_byteCnt <= '0;
            r_shift   <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
            r_checksum <= '0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: normal, gapped, empty, oversize, reset and reload scenarios.
module tb_rom_loader;
  localparam int AW = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          reload = 1'b0;
  logic          rom_write_enable;
  logic [AW-1:0] rom_write_address;
  logic [31:0]   rom_write_data;
  logic          cpu_reset;
  logic          load_done;
  logic          load_error;

  rom_loader_if bus ();

  rom_loader #(.ADDRESS_WIDTH(AW)) dut (
    .clock             (clock),
    .reset             (reset),
    .bus               (bus),
    .reload            (reload),
    .rom_write_enable  (rom_write_enable),
    .rom_write_address (rom_write_address),
    .rom_write_data    (rom_write_data),
    .cpu_reset         (cpu_reset),
    .load_done         (load_done),
    .load_error        (load_error)
  );

  always #5 clock = ~clock;

  int            compared = 0;
  int            mismatched = 0;
  int            wrCount = 0;
  int            base;
  logic [AW-1:0] wrAddr [0:31];
  logic [31:0]   wrData [0:31];
  logic [7:0]    prog   [0:10];
  int            progLen;

  // Log every write strobe; a strobe lasting two cycles would be logged twice.
  always @(negedge clock) begin
    if (rom_write_enable === 1'b1) begin
      if (wrCount < 32) begin
        wrAddr[wrCount] = rom_write_address;
        wrData[wrCount] = rom_write_data;
      end
      wrCount++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit gap);
    @(negedge clock);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    if (gap) begin
      @(negedge clock);
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'hA5;
    end
  endtask

  task automatic idle(input int n);
    @(negedge clock);
    bus.byte_valid = 1'b0;
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic pulseReload();
    @(negedge clock);
    bus.byte_valid = 1'b0;
    reload = 1'b1;
    @(negedge clock);
    reload = 1'b0;
    #1;
  endtask

  task automatic sendProgram(input bit gap, input int reloadAt);
    for (int i = 0; i < progLen; i++) begin
      if (i == reloadAt) pulseReload();
      applyStimulus(prog[i], gap);
    end
  endtask

  task automatic checkTwoWords(input string tag);
    checkOutput({tag, "_wrCount"}, 32'(wrCount - base), 32'd2);
    checkOutput({tag, "_addr0"}, 32'(wrAddr[base]), 32'd0);
    checkOutput({tag, "_data0"}, wrData[base], 32'h3C010001);
    checkOutput({tag, "_addr1"}, 32'(wrAddr[base + 1]), 32'd1);
    checkOutput({tag, "_data1"}, wrData[base + 1], 32'h34210002);
    checkOutput({tag, "_done"}, 32'(load_done), 32'd1);
    checkOutput({tag, "_cpuReset"}, 32'(cpu_reset), 32'd0);
    checkOutput({tag, "_error"}, 32'(load_error), 32'd0);
    checkOutput({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    prog[0] = 8'h00; prog[1] = 8'h02;
    prog[2] = 8'h3C; prog[3] = 8'h01; prog[4] = 8'h00; prog[5] = 8'h01;
    prog[6] = 8'h34; prog[7] = 8'h21; prog[8] = 8'h00; prog[9] = 8'h02;
    prog[10] = 8'h29;
`ifdef ROM_LOADER_CHECKSUM_EN
    progLen = 11;
`else
    progLen = 10;
`endif

    // Reset state
    #2 reset = 1'b0;
    #1;
    checkOutput("rst_cpuReset", 32'(cpu_reset), 32'd1);
    checkOutput("rst_we", 32'(rom_write_enable), 32'd0);
    checkOutput("rst_addr", 32'(rom_write_address), 32'd0);
    checkOutput("rst_data", rom_write_data, 32'd0);
    checkOutput("rst_done", 32'(load_done), 32'd0);
    checkOutput("rst_error", 32'(load_error), 32'd0);
    checkOutput("rst_ready", 32'(bus.byte_ready), 32'd1);
    @(negedge clock);
    reset = 1'b1;

    // Continuous two-word program
    base = wrCount;
    sendProgram(1'b0, -1);
    idle(3);
    checkTwoWords("cont");

    // Bytes offered in DONE are ignored
    applyStimulus(8'h77, 1'b0);
    applyStimulus(8'h88, 1'b0);
    idle(2);
    checkOutput("doneIgnore_wrCount", 32'(wrCount - base), 32'd2);
    checkOutput("doneIgnore_done", 32'(load_done), 32'd1);

    pulseReload();
    checkOutput("reload_cpuReset", 32'(cpu_reset), 32'd1);
    checkOutput("reload_done", 32'(load_done), 32'd0);
    checkOutput("reload_ready", 32'(bus.byte_ready), 32'd1);

    // Same program with byte_valid toggling every other cycle
    base = wrCount;
    sendProgram(1'b1, -1);
    idle(3);
    checkTwoWords("gap");
    pulseReload();

    // Empty program
    base = wrCount;
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0);
    idle(2);
    checkOutput("empty_wrCount", 32'(wrCount - base), 32'd0);
`ifdef ROM_LOADER_CHECKSUM_EN
    checkOutput("empty_checkDone", 32'(load_done), 32'd0);
    checkOutput("empty_checkReady", 32'(bus.byte_ready), 32'd1);
    checkOutput("empty_checkCpuReset", 32'(cpu_reset), 32'd1);
    applyStimulus(8'h00, 1'b0);
    idle(2);
`endif
    checkOutput("empty_done", 32'(load_done), 32'd1);
    checkOutput("empty_cpuReset", 32'(cpu_reset), 32'd0);
    pulseReload();

    // Count one past ROM capacity
    base = wrCount;
    applyStimulus(8'h04, 1'b0);
    applyStimulus(8'h01, 1'b0);
    idle(2);
    checkOutput("over_error", 32'(load_error), 32'd1);
    checkOutput("over_ready", 32'(bus.byte_ready), 32'd0);
    checkOutput("over_cpuReset", 32'(cpu_reset), 32'd1);
    checkOutput("over_done", 32'(load_done), 32'd0);
    checkOutput("over_wrCount", 32'(wrCount - base), 32'd0);
    pulseReload();
    checkOutput("overReload_error", 32'(load_error), 32'd0);

    // Count equal to ROM capacity is accepted, then reset mid-word
    applyStimulus(8'h04, 1'b0);
    applyStimulus(8'h00, 1'b0);
    idle(1);
    checkOutput("full_error", 32'(load_error), 32'd0);
    checkOutput("full_ready", 32'(bus.byte_ready), 32'd1);
    applyStimulus(8'hDE, 1'b0);
    applyStimulus(8'hAD, 1'b0);
    @(negedge clock);
    bus.byte_valid = 1'b0;
    reset = 1'b0;
    #1;
    checkOutput("midRst_cpuReset", 32'(cpu_reset), 32'd1);
    checkOutput("midRst_we", 32'(rom_write_enable), 32'd0);
    checkOutput("midRst_data", rom_write_data, 32'd0);
    checkOutput("midRst_ready", 32'(bus.byte_ready), 32'd1);
    @(negedge clock);
    reset = 1'b1;

    // Full program with a reload pulse mid-DATA that must be ignored
    base = wrCount;
    sendProgram(1'b0, 5);
    idle(3);
    checkTwoWords("midReload");
    pulseReload();
    checkOutput("restart_cpuReset", 32'(cpu_reset), 32'd1);
    checkOutput("restart_done", 32'(load_done), 32'd0);

`ifdef ROM_LOADER_CHECKSUM_EN
    // Checksum: 00^01^12^34^56^78 = 09
    base = wrCount;
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h12, 1'b0);
    applyStimulus(8'h34, 1'b0);
    applyStimulus(8'h56, 1'b0);
    applyStimulus(8'h78, 1'b0);
    applyStimulus(8'h09, 1'b0);
    idle(2);
    checkOutput("csGood_data", wrData[base], 32'h12345678);
    checkOutput("csGood_done", 32'(load_done), 32'd1);
    checkOutput("csGood_cpuReset", 32'(cpu_reset), 32'd0);
    pulseReload();
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h12, 1'b0);
    applyStimulus(8'h34, 1'b0);
    applyStimulus(8'h56, 1'b0);
    applyStimulus(8'h78, 1'b0);
    applyStimulus(8'h00, 1'b0);
    idle(2);
    checkOutput("csBad_error", 32'(load_error), 32'd1);
    checkOutput("csBad_done", 32'(load_done), 32'd0);
    checkOutput("csBad_cpuReset", 32'(cpu_reset), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 10; word-address width of instruction ROM write port.
REQ-002 clock  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserted (0) forces reset state immediately.
REQ-004 byte_valid  input  1  upstream byte available on byte_data.
REQ-005 byte_data  input  8  upstream program byte.
REQ-006 byte_ready  output  1  loader accepts byte this cycle; transfer = byte_valid & byte_ready.
REQ-007 reload  input  1  single-cycle request to restart loading.
REQ-008 rom_write_enable  output  1  one-cycle ROM word write strobe.
REQ-009 rom_write_address  output  ADDRESS_WIDTH  ROM word address.
REQ-010 rom_write_data  output  32  ROM word data.
REQ-011 cpu_reset  output  1  active-high reset to CPU; high while program not loaded.
REQ-012 load_done  output  1  program loaded successfully.
REQ-013 load_error  output  1  load aborted; program invalid.

Function
REQ-014 Stream format SHALL be: count_hi, count_lo (16-bit word count N, big-endian), then N words of 4 bytes each, big-endian (first byte -> bits 31:24).
REQ-015 States SHALL be COUNT_HI, COUNT_LO, DATA, CHECK, DONE, ERROR; reset state COUNT_HI.
REQ-016 byte_ready SHALL be 1 in COUNT_HI, COUNT_LO, DATA, CHECK and 0 in DONE, ERROR.
REQ-017 Transfer in COUNT_HI -> COUNT_LO; transfer in COUNT_LO -> DATA if N>0, else CHECK (CHECKSUM_EN) or DONE.
REQ-018 N > 2^ADDRESS_WIDTH SHALL be detected on count_lo transfer -> ERROR; N = 2^ADDRESS_WIDTH is legal.
REQ-019 In DATA a 2-bit byte counter SHALL assemble bytes; on 4th byte transfer rom_write_enable SHALL be 1 in the following cycle only, with rom_write_data = assembled word and rom_write_address = word index.
REQ-020 Word index SHALL start at 0 per load, increment after each write; last write at N-1, no wrap.
REQ-021 After Nth word transfer, next state SHALL be CHECK (CHECKSUM_EN) or DONE.
REQ-022 byte_valid with byte_ready=0 SHALL be ignored; gaps in byte_valid SHALL not affect assembly.
REQ-023 cpu_reset SHALL be 1 in all states except DONE; it falls the cycle DONE is entered, after the final rom write strobe has issued.
REQ-024 load_done = 1 only in DONE; load_error = 1 only in ERROR; both registered.
REQ-025 reload SHALL be honoured only in DONE or ERROR: next state COUNT_HI, cpu_reset 1, index and byte counter cleared, flags cleared.
REQ-026 reload in any other state SHALL be ignored; load continues unaffected.

Reset
REQ-027 reset=0 SHALL asynchronously set state COUNT_HI, cpu_reset=1, rom_write_enable=0, rom_write_address=0, rom_write_data=0, load_done=0, load_error=0, counters/checksum 0.
REQ-028 reset asserted mid-load SHALL discard partial word; no write strobe after reset release until 4 new data bytes.

Configuration
REQ-029 Macro ROM_LOADER_CHECKSUM_EN: when defined, state CHECK exists; running XOR of all count and data bytes compared to one trailing byte; match -> DONE, mismatch -> ERROR.
REQ-030 Without ROM_LOADER_CHECKSUM_EN: no CHECK state, no trailing byte; final word goes directly to DONE.

Verification
REQ-031 N=2, words 0x3C010001, 0x34210002 continuous -> writes addr0=0x3C010001, addr1=0x34210002, one strobe each, then load_done=1, cpu_reset=0.
REQ-032 Same stream, byte_valid toggled every other cycle -> identical writes and final state.
REQ-033 N=0 (bytes 0x00,0x00) -> no writes; DONE (checksum off) or CHECK awaiting byte 0x00 (checksum on).
REQ-034 ADDRESS_WIDTH=10, count 0x0401 -> load_error=1, byte_ready=0, cpu_reset=1, no writes.
REQ-035 CHECKSUM_EN, N=1, word 0x12345678, trailing 0x09 -> DONE; trailing 0x00 -> ERROR, cpu_reset stays 1.
REQ-036 reset pulsed low after 2 data bytes, then reload full stream; reload pulsed mid-DATA -> ignored; in DONE -> restart, cpu_reset returns 1.
